// File: rtl/adc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_pkg : shared types and the rounded/clamped average helper
// Rev 1.0
// ----------------------------------------------------------------------------
package adc_pkg;

   localparam int DATA_W_DEF = 12;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACQ  = 1'b1
   } state_t;

   // Round-half-up divide by 2^avg_log2, then clamp to the data range.
   function automatic logic [31:0] avg_round(input logic [31:0] sum,
                                             input int          data_w,
                                             input int          avg_log2);
      logic [31:0] w_bias;
      logic [31:0] w_q;
      logic [31:0] w_max;
      w_bias = (avg_log2 > 0) ? (32'd1 << (avg_log2 - 1)) : 32'd0;
      w_q    = (sum + w_bias) >> avg_log2;
      w_max  = (32'd1 << data_w) - 32'd1;
      return (w_q > w_max) ? w_max : w_q;
   endfunction

endpackage
`default_nettype wire

// File: rtl/adc_avg_accum.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_avg_accum : box-car accumulator producing one rounded result per 2^AVG_LOG2 samples
// Rev 1.0
// ----------------------------------------------------------------------------
module adc_avg_accum
   import adc_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int AVG_LOG2 = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,
   input  logic              i_s_valid,
   input  logic [DATA_W-1:0] i_s_reg,
   output logic [DATA_W-1:0] o_res,
   output logic              o_res_valid
);

   generate
      if (AVG_LOG2 == 0) begin : g_pass
         logic w_unused;
         assign w_unused    = ^{clk, rst, i_clr};
         assign o_res       = i_s_reg;
         assign o_res_valid = i_s_valid;
      end else begin : g_avg
         localparam int ACC_W = DATA_W + AVG_LOG2;

         logic [ACC_W-1:0]    r_acc;
         logic [AVG_LOG2-1:0] r_n_cnt;
         logic                w_last;
         logic [31:0]         w_avg;
         logic                w_unused_avg;

         assign w_last       = &r_n_cnt;
         // The closing sample is folded in combinationally so the result is ready with s_valid.
         assign w_avg        = avg_round(32'(r_acc) + 32'(i_s_reg), DATA_W, AVG_LOG2);
         assign o_res        = w_avg[DATA_W-1:0];
         assign w_unused_avg = ^w_avg[31:DATA_W];
         assign o_res_valid  = i_s_valid && w_last;

         always_ff @(posedge clk) begin
            if (rst || i_clr || (i_s_valid && w_last)) begin
               r_acc   <= '0;
               r_n_cnt <= '0;
            end else if (i_s_valid) begin
               r_acc   <= r_acc + ACC_W'(i_s_reg);
               r_n_cnt <= r_n_cnt + AVG_LOG2'(1);
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/adc_sample_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// adc_sample_ctrl : paced ADC sampling, optional averaging, FIFO write with overflow count
// Rev 1.0
// ----------------------------------------------------------------------------
module adc_sample_ctrl
   import adc_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DIV      = 5,
   parameter int AVG_LOG2 = 2,
   parameter int OVF_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_en,
   input  logic              i_clr_ovf,
   input  logic [DATA_W-1:0] i_adc_data,
   input  logic              i_fifo_full,
   output logic [DATA_W-1:0] o_fifo_wdata,
   output logic              o_fifo_wren,
   output logic              o_sample_tick,
   output logic              o_ovf_sticky,
   output logic [OVF_W-1:0]  o_ovf_cnt
);

   localparam int DIV_W = $clog2(DIV);
   localparam logic [DIV_W-1:0] c_DIV_MAX = DIV_W'(DIV - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_acq;
   logic [DIV_W-1:0]  r_div_cnt;
   logic              w_tick;
   logic [DATA_W-1:0] r_s_reg;
   logic              r_s_valid;
   logic [DATA_W-1:0] w_res;
   logic              w_res_valid;
   logic              r_pend;
   logic [DATA_W-1:0] r_pend_data;
   logic              w_wren;
   logic              w_ovf_evt;
   logic              r_ovf_sticky;
   logic [OVF_W-1:0]  r_ovf_cnt;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acq       = 1'b0;
      case (r_state)
         IDLE: if (i_en) w_state_nxt = ACQ;
         ACQ: begin
            w_acq = 1'b1;
            if (!i_en) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || !w_acq || (r_div_cnt == c_DIV_MAX)) r_div_cnt <= '0;
      else                                           r_div_cnt <= r_div_cnt + DIV_W'(1);
   end

   assign w_tick = w_acq && (r_div_cnt == c_DIV_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s_reg   <= '0;
         r_s_valid <= 1'b0;
      end else begin
         r_s_valid <= w_tick;
         if (w_tick) r_s_reg <= i_adc_data;
      end
   end

   adc_avg_accum #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
   ) u_accum (
      .clk         (clk),
      .rst         (rst),
      .i_clr       (!w_acq),
      .i_s_valid   (r_s_valid),
      .i_s_reg     (r_s_reg),
      .o_res       (w_res),
      .o_res_valid (w_res_valid)
   );

   assign w_wren    = r_pend && !i_fifo_full;
   // A result is lost only if the holding register is occupied and cannot drain this cycle.
   assign w_ovf_evt = w_res_valid && r_pend && !w_wren;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend      <= 1'b0;
         r_pend_data <= '0;
      end else if (w_res_valid) begin
         r_pend <= 1'b1;
         if (!w_ovf_evt) r_pend_data <= w_res;
      end else if (w_wren) begin
         r_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || i_clr_ovf) begin
         r_ovf_cnt    <= '0;
         r_ovf_sticky <= 1'b0;
      end else if (w_ovf_evt) begin
         r_ovf_sticky <= 1'b1;
         if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
      end
   end

   assign o_fifo_wren   = w_wren;
   assign o_fifo_wdata  = r_pend_data;
   assign o_sample_tick = w_tick;
   assign o_ovf_sticky  = r_ovf_sticky;
   assign o_ovf_cnt     = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_adc_sample_ctrl : directed and random stimulus against a cycle-level reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_adc_sample_ctrl;

   localparam int DIV = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_en = 1'b0;
   logic        i_clr_ovf = 1'b0;
   logic [11:0] i_adc_data = '0;
   logic        i_fifo_full = 1'b0;

   logic [11:0] o_wdata0, o_wdata1;
   logic        o_wren0, o_wren1, o_tick0, o_tick1, o_sticky0, o_sticky1;
   logic [15:0] o_ovf0;
   logic [2:0]  o_ovf1;

   always #5 clk = ~clk;

   adc_sample_ctrl #(.DATA_W(12), .DIV(DIV), .AVG_LOG2(2), .OVF_W(16)) u_dut0 (
      .clk(clk), .rst(rst), .i_en(i_en), .i_clr_ovf(i_clr_ovf), .i_adc_data(i_adc_data),
      .i_fifo_full(i_fifo_full), .o_fifo_wdata(o_wdata0), .o_fifo_wren(o_wren0),
      .o_sample_tick(o_tick0), .o_ovf_sticky(o_sticky0), .o_ovf_cnt(o_ovf0));

   adc_sample_ctrl #(.DATA_W(12), .DIV(DIV), .AVG_LOG2(0), .OVF_W(3)) u_dut1 (
      .clk(clk), .rst(rst), .i_en(i_en), .i_clr_ovf(i_clr_ovf), .i_adc_data(i_adc_data),
      .i_fifo_full(i_fifo_full), .o_fifo_wdata(o_wdata1), .o_fifo_wren(o_wren1),
      .o_sample_tick(o_tick1), .o_ovf_sticky(o_sticky1), .o_ovf_cnt(o_ovf1));

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int base = 0;

   // Reference model: one entry per DUT (0: average of 4, 16-bit counter; 1: pass-through, 3-bit counter).
   bit        m_acq;
   int        m_phase;
   bit        m_sval;
   int        m_sv;
   int        m_sum [2];
   int        m_n [2];
   bit        m_pend [2];
   int        m_pdata [2];
   int        m_ovf [2];
   bit        m_sticky [2];

   int wq0[$], wc0[$], wq1[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acq = 0; m_phase = 0; m_sval = 0; m_sv = 0;
      for (int k = 0; k < 2; k++) begin
         m_sum[k] = 0; m_n[k] = 0; m_pend[k] = 0; m_pdata[k] = 0; m_ovf[k] = 0; m_sticky[k] = 0;
      end
   endtask

   task automatic step(input logic e, input logic f, input logic cl, input logic r, input logic [11:0] d);
      bit exp_tick;
      @(posedge clk);
      #1;
      i_en = e; i_fifo_full = f; i_clr_ovf = cl; rst = r; i_adc_data = d;
      #2;
      exp_tick = m_acq && (m_phase == DIV - 1);
      check_val("tick0",   32'(o_tick0),   32'(exp_tick));
      check_val("tick1",   32'(o_tick1),   32'(exp_tick));
      check_val("wren0",   32'(o_wren0),   32'(m_pend[0] && !f));
      check_val("wren1",   32'(o_wren1),   32'(m_pend[1] && !f));
      check_val("wdata0",  32'(o_wdata0),  32'(m_pdata[0]));
      check_val("wdata1",  32'(o_wdata1),  32'(m_pdata[1]));
      check_val("ovf0",    32'(o_ovf0),    32'(m_ovf[0]));
      check_val("ovf1",    32'(o_ovf1),    32'(m_ovf[1]));
      check_val("sticky0", 32'(o_sticky0), 32'(m_sticky[0]));
      check_val("sticky1", 32'(o_sticky1), 32'(m_sticky[1]));
      if (o_wren0 === 1'b1) begin wq0.push_back(int'(o_wdata0)); wc0.push_back(cyc); end
      if (o_wren1 === 1'b1) wq1.push_back(int'(o_wdata1));

      if (r) begin
         model_reset();
      end else begin
         for (int k = 0; k < 2; k++) begin
            int  navg, omax, res;
            bit  wr, have;
            navg = (k == 0) ? 4 : 1;
            omax = (k == 0) ? 65535 : 7;
            wr   = m_pend[k] && !f;
            have = 0; res = 0;
            if (m_sval) begin
               m_sum[k] += m_sv;
               m_n[k]++;
               if (m_n[k] == navg) begin
                  res = (m_sum[k] + navg / 2) / navg;
                  if (res > 4095) res = 4095;
                  have = 1; m_sum[k] = 0; m_n[k] = 0;
               end
            end
            if (!m_acq) begin m_sum[k] = 0; m_n[k] = 0; end
            if (have) begin
               if (m_pend[k] && !wr) begin
                  if (m_ovf[k] < omax) m_ovf[k]++;
                  m_sticky[k] = 1;
               end else begin
                  m_pdata[k] = res; m_pend[k] = 1;
               end
            end else if (wr) begin
               m_pend[k] = 0;
            end
            if (cl) begin m_ovf[k] = 0; m_sticky[k] = 0; end
         end
         m_sval  = exp_tick;
         m_sv    = int'(d);
         m_phase = m_acq ? (m_phase + 1) % DIV : 0;
         m_acq   = e;
      end
      cyc++;
   endtask

   task automatic start_test();
      step(0, 0, 0, 1, 12'd0);
      wq0.delete(); wc0.delete(); wq1.delete();
      base = cyc;
   endtask

   function automatic int q_at(input int q[$], input int i);
      return (q.size() > i) ? q[i] : -1;
   endfunction

   initial begin
      int idx;
      logic [11:0] rd;
      bit re, rf;
      int rnd_seq[8];
      repeat (2) @(posedge clk);
      model_reset();

      // Basic average: 100..103 then 104..107
      start_test();
      for (int c = 0; c <= 45; c++) begin
         idx = (c > 0) ? (c - 1) / 5 : 0;
         step(1, 0, 0, 0, 12'(100 + idx));
      end
      check_val("basic_word", 32'(q_at(wq0, 0)), 32'd102);
      check_val("basic_lat",  32'(q_at(wc0, 0) - base), 32'd22);
      check_val("basic_gap",  32'(q_at(wc0, 1) - q_at(wc0, 0)), 32'd20);
      check_val("basic_word2", 32'(q_at(wq0, 1)), 32'd106);

      // Rounding and clamp
      rnd_seq = '{0, 0, 0, 2, 4095, 4095, 4095, 4095};
      start_test();
      for (int c = 0; c <= 45; c++) begin
         idx = (c > 0) ? (c - 1) / 5 : 0;
         if (idx > 7) idx = 7;
         step(1, 0, 0, 0, 12'(rnd_seq[idx]));
      end
      check_val("round_up", 32'(q_at(wq0, 0)), 32'd1);
      check_val("clamp_max", 32'(q_at(wq0, 1)), 32'd4095);

      // Pass-through instance
      start_test();
      for (int c = 0; c <= 10; c++) step(1, 0, 0, 0, 12'hABC);
      check_val("pass_word", 32'(q_at(wq1, 0)), 32'h0ABC);

      // Back-pressure across two result boundaries
      start_test();
      for (int c = 0; c <= 54; c++) step(1, 1, 0, 0, (c <= 20) ? 12'd10 : 12'd20);
      check_val("bp_nowrite", 32'(wq0.size()), 32'd0);
      check_val("bp_ovf",     32'(o_ovf0), 32'd1);
      check_val("bp_sticky",  32'(o_sticky0), 32'd1);
      check_val("bp_sat",     32'(o_ovf1), 32'd7);
      for (int c = 55; c <= 60; c++) step(1, 0, 0, 0, 12'd20);
      check_val("bp_once", 32'(wq0.size()), 32'd1);
      check_val("bp_word", 32'(q_at(wq0, 0)), 32'd10);

      // Write-and-load collision
      start_test();
      for (int c = 0; c <= 50; c++) step(1, (c < 41), 0, 0, (c <= 20) ? 12'd10 : 12'd20);
      check_val("col_cnt",   32'(wq0.size()), 32'd2);
      check_val("col_old",   32'(q_at(wq0, 0)), 32'd10);
      check_val("col_new",   32'(q_at(wq0, 1)), 32'd20);
      check_val("col_when",  32'(q_at(wc0, 0) - base), 32'd41);
      check_val("col_noovf", 32'(o_ovf0), 32'd0);

      // en dropped after two samples
      start_test();
      for (int c = 0; c <= 45; c++)
         step(!(c >= 12 && c <= 14), 0, 0, 0, (c <= 11) ? 12'd1000 : 12'd50);
      check_val("endrop_word", 32'(q_at(wq0, 0)), 32'd50);

      // Reset with a pending word
      start_test();
      for (int c = 0; c <= 24; c++) step(1, 1, 0, 0, 12'd33);
      step(1, 1, 0, 1, 12'd33);
      step(1, 0, 0, 0, 12'd33);
      check_val("rst_wren", 32'(o_wren0), 32'd0);
      check_val("rst_ovf1", 32'(o_ovf1), 32'd0);
      check_val("rst_stk1", 32'(o_sticky1), 32'd0);

      // clr_ovf coincident with an overflow
      start_test();
      for (int c = 0; c <= 62; c++) begin
         step(1, 1, (c == 61), 0, 12'(c));
         if (c == 45) check_val("clr_pre", 32'(o_ovf0), 32'd1);
      end
      check_val("clr_cnt", 32'(o_ovf0), 32'd0);
      check_val("clr_stk", 32'(o_sticky0), 32'd0);

      // Random traffic
      start_test();
      re = 1; rf = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 39) == 0) re = !re;
         if ($urandom_range(0, 7) == 0) rf = !rf;
         rd = 12'($urandom);
         step(re, rf, ($urandom_range(0, 99) == 0), ($urandom_range(0, 499) == 0), rd);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/adc_sample_ctrl.md
# adc_sample_ctrl

Upstream stage of the ADC→FIFO→SPI chain. It paces sampling of the 12-bit parallel ADC bus, optionally box-car averages 2^AVG_LOG2 samples, and writes each result into the sample FIFO through its `wren_i`/`full_o` handshake. Full-FIFO back-pressure is absorbed by a one-entry holding register, and lost results are counted. The block runs in the FIFO clock domain.

## Interface
- `DATA_W`, 12: ADC sample and FIFO word width.
- `DIV`, 5: clock cycles per sample tick. Must be ≥ 3.
- `AVG_LOG2`, 2: log2 of samples averaged per output. 0 means pass-through.
- `OVF_W`, 16: overflow counter width.
- `clk`, in, 1: single clock (FIFO clock). All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: acquisition enable.
- `clr_ovf`, in, 1: single-cycle pulse that clears the overflow counter and the sticky flag.
- `adc_data`, in, DATA_W: ADC parallel output. Stable at the tick edge.
- `fifo_full`, in, 1: FIFO full flag.
- `fifo_wdata`, out, DATA_W: word to the FIFO. Valid while `fifo_wren` is high.
- `fifo_wren`, out, 1: FIFO write enable, one cycle per word.
- `sample_tick`, out, 1: pulse on every ADC sample instant (debug/ILA).
- `ovf_sticky`, out, 1: set on the first dropped result. Cleared only by `clr_ovf` or reset.
- `ovf_cnt`, out, OVF_W: dropped-result count. Saturates at all-ones.

## Operation
- **FSM states:** IDLE, ACQ.
  - IDLE → ACQ when `en`=1.
  - ACQ → IDLE when `en`=0.
- **Divider counter `div_cnt`** (0..DIV-1):
  - Held at 0 in IDLE.
  - In ACQ it increments and wraps at DIV-1.
  - `sample_tick` = ACQ && `div_cnt`==DIV-1.
  - The first tick is the DIV-th cycle after entering ACQ.
- **On a tick:** `adc_data` is registered into `s_reg`, and `s_valid` is set for one cycle.
- **Accumulator** (DATA_W+AVG_LOG2 bits) and **sample counter `n_cnt`** (AVG_LOG2 bits):
  - When `s_valid`=1, add `s_reg`.
  - On the 2^AVG_LOG2-th sample, compute result = (acc + s_reg + 2^(AVG_LOG2-1)) >> AVG_LOG2, clamped to 2^DATA_W-1.
  - Then clear the accumulator and `n_cnt` to 0.
  - The rounding term is 0 when AVG_LOG2=0.
- **Holding register `pend`/`pend_data`:**
  - A new result loads `pend_data` and sets `pend`.
  - `fifo_wren` = `pend` && !`fifo_full`. This output is combinational.
  - `fifo_wdata` = `pend_data`.
  - `pend` clears at the end of any cycle in which `fifo_wren`=1.
- **Overflow:**
  - A result that arrives while `pend`=1 and no write happens that cycle is discarded. `pend_data` is unchanged, `ovf_cnt` increments (saturating), and `ovf_sticky` is set.
  - If a write happens in the same cycle, the new result loads `pend_data` and `pend` stays 1. No overflow is recorded.
- **`en` deasserted mid-average:** the accumulator and `n_cnt` clear and the partial average is discarded. `pend` is kept and still drains to the FIFO.
- **`clr_ovf` in the same cycle as an overflow event:** clear wins. The counter is 0 and sticky is 0 afterwards.

## Timing
- **Reset values:**
  - State IDLE.
  - `div_cnt`, `n_cnt`, accumulator, `pend`, `pend_data`, `ovf_cnt` all 0; `ovf_sticky` 0.
  - Outputs `fifo_wren`=0, `fifo_wdata`=0, `sample_tick`=0.
- **Reset mid-operation:** everything returns to reset values on the next edge. A pending word is lost and not counted.
- **Latency:** last tick at cycle T → `s_valid` at T+1 → `pend`=1 and earliest `fifo_wren` at T+2.
- **Throughput:** at most one word per DIV·2^AVG_LOG2 cycles. DIV≥3 guarantees the holding register drains between results when the FIFO is not full.
- **`fifo_full` timing:** `fifo_full` is sampled in the same cycle as `fifo_wren`. The block never asserts `fifo_wren` while `fifo_full`=1.

## Structure
- **Package `adc_pkg`:**
  - `DATA_W` default.
  - FSM state type {IDLE, ACQ}.
  - Function computing the rounded, clamped average.
- **Sub-module `adc_avg_accum`:**
  - Contains the accumulator, `n_cnt` and rounding.
  - Inputs: `s_valid`, `s_reg`, clear.
  - Outputs: result and `res_valid`.
- **Top level:** FSM, divider, holding register and overflow logic.

## Test plan
All cases use DIV=5 and AVG_LOG2=2 unless stated otherwise.
- **Basic average:** `en` held high; samples 100, 101, 102, 103 at successive ticks. Expect one `fifo_wren` pulse with `fifo_wdata`=102, 2 cycles after the 4th tick, then 20 cycles to the next word.
- **Rounding and clamp:** samples 0, 0, 0, 2 → 1. Samples 4095 ×4 → 4095. With AVG_LOG2=0, sample 0xABC → 0xABC.
- **Back-pressure:** `fifo_full`=1 across 2 result boundaries → no `fifo_wren`, `ovf_cnt`=1, `ovf_sticky`=1. On release, the first result is written exactly once.
- **Write-and-load collision:** `fifo_full` deasserts in the same cycle the next result arrives → old word written, new word held, `ovf_cnt` unchanged.
- **`en` drop mid-average:** after 2 samples, drop `en` for 3 cycles, then feed 4 samples of 50 → output 50, with no contribution from the partial samples.
- **Reset and clear:** `rst` asserted with `pend`=1 → `fifo_wren`=0 next cycle and all counters 0. `clr_ovf` coincident with an overflow → `ovf_cnt`=0.
